// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, 8N1 framing with optional parity, valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       ap_rstn,
  input  logic       rx,
  input  logic       pairty,
  output logic [7:0] data,
  output logic       ap_vaild,
  input  logic       ap_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, STAR, DATA, PARI, STOP, WAIT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_bad_q, par_bad_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             sample_bit;

`ifdef UART_RX_MAJORITY_EN
  // Decision one count past the centre; after the start bit every later sample shifts by one too.
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(OVERSAMPLE / 2);
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  assign sample_bit = rx_s_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;

    if (valid_q && ap_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = STAR;
          cnt_d   = '0;
        end
      end
      STAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == START_CNT) begin
          if (sample_bit) begin
            state_d = IDLE;
          end else begin
            par_en_d = pairty;
            cnt_d    = '0;
            bit_d    = '0;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {sample_bit, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? PARI : STOP;
          end
        end
      end
      PARI: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_bad_d = sample_bit ^ (^shift_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          data_d  = shift_q;
          valid_d = 1'b1;
          perr_d  = par_en_q & par_bad_q;
          ferr_d  = ~sample_bit;
          // A completion coinciding with acceptance replaces the byte without overrun.
          if (valid_q && !ap_ready) begin
            ovr_d = 1'b1;
          end
          state_d = sample_bit ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bad_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data       = data_q;
  assign ap_vaild   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model plus per-cycle output comparison.
module tb_uart_rx;

  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       ap_rstn = 1'b0;
  logic       rx = 1'b1;
  logic       pairty = 1'b0;
  logic       ap_ready = 1'b0;
  logic [7:0] data;
  logic       ap_vaild, parity_err, frame_err, overrun;

  uart_rx #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .clk(clk), .ap_rstn(ap_rstn), .rx(rx), .pairty(pairty),
    .data(data), .ap_vaild(ap_vaild), .ap_ready(ap_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int         when;
    logic [7:0] b;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_ovr = 1'b0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  // Frame-level model: a byte lands at its predicted completion edge.
  always @(posedge clk) begin
    cyc++;
    if (!ap_rstn) begin
      m_data = 8'h00; m_valid = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
      if (m_valid && !ap_ready) m_ovr = 1'b1;
      m_data  = exp_q[0].b;
      m_pe    = exp_q[0].pe;
      m_fe    = exp_q[0].fe;
      m_valid = 1'b1;
      void'(exp_q.pop_front());
      $display("frame @%0d: data=%h parity_err=%b frame_err=%b overrun=%b", cyc, m_data, m_pe, m_fe, m_ovr);
    end else if (m_valid && ap_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!ap_rstn) begin
      chk("data", data, 8'h00);
      chk("ap_vaild", {7'd0, ap_vaild}, 8'h00);
      chk("parity_err", {7'd0, parity_err}, 8'h00);
      chk("frame_err", {7'd0, frame_err}, 8'h00);
      chk("overrun", {7'd0, overrun}, 8'h00);
    end else begin
      chk("data", data, m_data);
      chk("ap_vaild", {7'd0, ap_vaild}, {7'd0, m_valid});
      chk("parity_err", {7'd0, parity_err}, {7'd0, m_pe});
      chk("frame_err", {7'd0, frame_err}, {7'd0, m_fe});
      chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
    end
  end

  // Completion edge: stop-bit centre (OS*(9+p)+OS/2 after the start edge) + 2 sync + 1 register.
  function automatic int latency(input logic has_par);
    return OS * (9 + (has_par ? 1 : 0)) + OS / 2 + 3 + MAJ;
  endfunction

  // Occupies exactly (frame bits)*OS cycles so consecutive calls are back-to-back.
  task automatic send_frame(input logic [7:0] b, input logic has_par, input logic par_bit,
                            input logic stop_bit);
    logic [9:0] bits;
    int         nb;
    int         s;
    exp_t       e;
    for (int i = 0; i < 8; i++) bits[i] = b[i];
    if (has_par) begin
      bits[8] = par_bit; bits[9] = stop_bit; nb = 10;
    end else begin
      bits[8] = stop_bit; bits[9] = 1'b1; nb = 9;
    end
    @(posedge clk); #1;
    s  = cyc;
    rx = 1'b0;
    e.when = s + latency(has_par);
    e.b    = b;
    e.pe   = has_par & (par_bit ^ (^b));
    e.fe   = ~stop_bit;
    exp_q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      repeat (OS) @(posedge clk);
      #1 rx = bits[i];
    end
    repeat (OS - 1) @(posedge clk);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 ap_ready = 1'b1;
    @(posedge clk); #1 ap_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 ap_rstn = 1'b0; rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 ap_rstn = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish by 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #2;
    chk("rst data", data, 8'h00);
    chk("rst ap_vaild", {7'd0, ap_vaild}, 8'h00);
    chk("rst overrun", {7'd0, overrun}, 8'h00);
    #1 ap_rstn = 1'b1;
    repeat (20) @(posedge clk);

    // No-parity byte, then a one-cycle accept
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    #2;
    chk("A5 data", data, 8'hA5);
    chk("A5 ap_vaild", {7'd0, ap_vaild}, 8'h01);
    chk("A5 parity_err", {7'd0, parity_err}, 8'h00);
    chk("A5 frame_err", {7'd0, frame_err}, 8'h00);
    pulse_ready();
    #1 chk("A5 accepted ap_vaild", {7'd0, ap_vaild}, 8'h00);

    // Parity frames
    pairty = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    #2 chk("3C good parity_err", {7'd0, parity_err}, 8'h00);
    pulse_ready();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    #2;
    chk("3C bad data", data, 8'h3C);
    chk("3C bad parity_err", {7'd0, parity_err}, 8'h01);
    pulse_ready();
    pairty = 1'b0;

    // Glitch rejection
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    chk("glitch ap_vaild", {7'd0, ap_vaild}, 8'h00);
    chk("glitch data", data, 8'h3C);

    // Framing error followed by a held break
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    chk("break data", data, 8'h55);
    chk("break frame_err", {7'd0, frame_err}, 8'h01);
    chk("break ap_vaild", {7'd0, ap_vaild}, 8'h01);
    repeat (20) @(posedge clk);
    pulse_ready();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    #2;
    chk("0F data", data, 8'h0F);
    chk("0F frame_err", {7'd0, frame_err}, 8'h00);
    pulse_ready();

    // Overrun with no consumer
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    #2;
    chk("ovr data", data, 8'h22);
    chk("ovr ap_vaild", {7'd0, ap_vaild}, 8'h01);
    chk("ovr overrun", {7'd0, overrun}, 8'h01);
    do_reset();
    chk("ovr cleared", {7'd0, overrun}, 8'h00);

    // Acceptance in the completion cycle of the second byte
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (OS * 10 + latency(1'b0)) @(posedge clk);
        #1 ap_ready = 1'b1;
        @(posedge clk);
        #1 ap_ready = 1'b0;
      end
    join
    #2;
    chk("accept-race data", data, 8'h22);
    chk("accept-race ap_vaild", {7'd0, ap_vaild}, 8'h01);
    chk("accept-race overrun", {7'd0, overrun}, 8'h00);

    // Reset during data bit 3 of 0xF0 (bits 0..3 are all 0)
    @(posedge clk); #1 rx = 1'b0;
    repeat (4 * OS + OS / 2) @(posedge clk);
    #1 ap_rstn = 1'b0; rx = 1'b1;
    #1;
    chk("midrst data", data, 8'h00);
    chk("midrst ap_vaild", {7'd0, ap_vaild}, 8'h00);
    chk("midrst overrun", {7'd0, overrun}, 8'h00);
    repeat (4) @(posedge clk);
    #1 ap_rstn = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    #2;
    chk("81 data", data, 8'h81);
    chk("81 ap_vaild", {7'd0, ap_vaild}, 8'h01);
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
